// File: rtl/qbus_cycle_master_pkg.sv
// rtl/qbus_cycle_master_pkg.sv - shared states, timing defaults and I/O-page decode for the QBUS cycle master
// Purpose: state encoding, default timing counts (clk20 cycles), BS7 I/O-page decode helper.
// Ports:   none (package).
package qbus_cycle_master_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ASET,
      ST_SYNC,
      ST_DPREP,
      ST_XFER,
      ST_DSETL,
      ST_RELEASE,
      ST_FIN
   } state_t;

   localparam int TIMER_W            = 8;
   localparam int ASETUP_DEF         = 3;
   localparam int AHOLD_DEF          = 2;
   localparam int DSKEW_DEF          = 2;
   localparam int DIN_SETTLE_DEF     = 4;
   localparam int NXM_TICKS_DEF      = 200;

   // Top 4 KW of the 22-bit byte address space is the I/O page.
   localparam logic [8:0] IO_PAGE_BS7 = 9'o777;

   function automatic logic is_io_page(input logic [21:0] a);
      return (a[21:13] == IO_PAGE_BS7);
   endfunction

endpackage

// File: rtl/qbus_cycle_master_if.sv
// rtl/qbus_cycle_master_if.sv - device request and QBUS/Am2908 signal bundle for the cycle master
// Purpose: groups the owning-device request/response and the QBUS/transceiver lines.
// Ports:   master modport = the cycle master (drives bus/transceiver outputs and status);
//          slave modport  = the environment (device, receivers, responder).
//          byte_mode carries the DATOB request bit.
interface qbus_cycle_master_if;

   logic        RINIT;
   logic        RRPLY;
   logic [15:0] RDAL;

   logic        start;
   logic        write;
   logic        byte_mode;
   logic [21:0] addr;
   logic [15:0] wdata;

   logic        busy;
   logic        done;
   logic        nxm;
   logic [15:0] rdata;

   logic [21:0] TDAL;
   logic        TWTBT;
   logic        TBS7;
   logic        TSYNC;
   logic        TDIN;
   logic        TDOUT;
   logic        DALtx;
   logic        DALst;
   logic        DALbe;

   modport master (
      input  RINIT, RRPLY, RDAL, start, write, byte_mode, addr, wdata,
      output busy, done, nxm, rdata,
      output TDAL, TWTBT, TBS7, TSYNC, TDIN, TDOUT, DALtx, DALst, DALbe
   );

   modport slave (
      output RINIT, RRPLY, RDAL, start, write, byte_mode, addr, wdata,
      input  busy, done, nxm, rdata,
      input  TDAL, TWTBT, TBS7, TSYNC, TDIN, TDOUT, DALtx, DALst, DALbe
   );

endinterface

// File: rtl/qbus_cycle_master_sync.sv
// rtl/qbus_cycle_master_sync.sv - two-flop synchronizer for asynchronous QBUS inputs
// Purpose: brings an asynchronous level (RRPLY) into the clk20 domain.
// Ports:   clk20, reset_L (async clear), d (async in), q (synchronized out).
module qbus_sync (
   input  logic clk20,
   input  logic reset_L,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk20 or negedge reset_L) begin
      if (!reset_L) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/qbus_cycle_master.sv
// rtl/qbus_cycle_master.sv - QBUS initiator for single DATI/DATO(B) cycles
// Purpose: while the device holds bus mastership, runs one DATI/DATO/DATOB cycle: drives
//          TSYNC/TDIN/TDOUT, sequences the Am2908 transceivers (DALtx/DALst/DALbe), returns
//          read data or reports NXM when RRPLY does not assert/negate in time.
// Ports:   clk20 (20 MHz), reset_L (async, active low), bus (qbus_cycle_master_if.master):
//          RINIT sync abort, RRPLY async reply, RDAL read data, start/write/byte_mode/addr/wdata
//          request, busy/done/nxm/rdata status, TDAL/TWTBT/TBS7/TSYNC/TDIN/TDOUT and
//          DALtx/DALst/DALbe toward the bus.
module qbus_cycle_master
   import qbus_cycle_master_pkg::*;
#(
   parameter int ASETUP     = ASETUP_DEF,
   parameter int AHOLD      = AHOLD_DEF,
   parameter int DSKEW      = DSKEW_DEF,
   parameter int DIN_SETTLE = DIN_SETTLE_DEF,
   parameter int NXM_TICKS  = NXM_TICKS_DEF
) (
   input  logic                clk20,
   input  logic                reset_L,
   qbus_cycle_master_if.master bus
);

   if (NXM_TICKS >= 256 || NXM_TICKS < 1) begin : g_bad_nxm
      $error("NXM_TICKS must be in 1..255 for the 8-bit timer");
   end

   // Each phase lasts N cycles: the timer counts 0..N-1 within the state.
   localparam logic [TIMER_W-1:0] ASETUP_LAST = TIMER_W'(ASETUP - 1);
   localparam logic [TIMER_W-1:0] AHOLD_LAST  = TIMER_W'(AHOLD - 1);
   localparam logic [TIMER_W-1:0] DSKEW_LAST  = TIMER_W'(DSKEW - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(DIN_SETTLE - 1);
   localparam logic [TIMER_W-1:0] NXM_LIMIT   = TIMER_W'(NXM_TICKS);

   state_t               state, next_state;
   logic [TIMER_W-1:0]   cnt;
   logic                 req_write, req_byte;
   logic [21:0]          req_addr;
   logic [15:0]          req_wdata;
   logic [15:0]          rdata_q;
   logic                 rply_s;
   logic                 sample_rdal;

   logic [21:0]          tdal;
   logic                 twtbt, tbs7, tsync, tdin, tdout, daltx, dalst, dalbe;
   logic                 done_c, nxm_c;

   qbus_sync u_rply_sync (
      .clk20   (clk20),
      .reset_L (reset_L),
      .d       (bus.RRPLY),
      .q       (rply_s)
   );

   always_ff @(posedge clk20 or negedge reset_L) begin
      if (!reset_L) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_write <= 1'b0;
         req_byte  <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         rdata_q   <= '0;
      end else if (bus.RINIT) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         state <= next_state;
         // Timer restarts on every state change so each phase counts from 0.
         if (next_state != state)
            cnt <= '0;
         else if (cnt != {TIMER_W{1'b1}})
            cnt <= cnt + 1'b1;
         if (state == ST_IDLE && bus.start) begin
            req_write <= bus.write;
            req_byte  <= bus.byte_mode;
            req_addr  <= bus.addr;
            req_wdata <= bus.wdata;
         end
         if (sample_rdal)
            rdata_q <= bus.RDAL;
      end
   end

   always_comb begin
      next_state  = state;
      sample_rdal = 1'b0;
      tdal        = '0;
      twtbt       = 1'b0;
      tbs7        = 1'b0;
      tsync       = 1'b0;
      tdin        = 1'b0;
      tdout       = 1'b0;
      daltx       = 1'b0;
      dalst       = 1'b0;
      dalbe       = 1'b0;
      done_c      = 1'b0;
      nxm_c       = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (bus.start)
               next_state = ST_ADDR;
         end
         ST_ADDR: begin
            tdal       = req_addr;
            daltx      = 1'b1;
            dalst      = 1'b1;
            twtbt      = req_write;
            tbs7       = is_io_page(req_addr);
            next_state = ST_ASET;
         end
         ST_ASET: begin
            tdal  = req_addr;
            daltx = 1'b1;
            dalbe = 1'b1;
            twtbt = req_write;
            tbs7  = is_io_page(req_addr);
            if (cnt == ASETUP_LAST)
               next_state = ST_SYNC;
         end
         ST_SYNC: begin
            tsync = 1'b1;
            tdal  = req_addr;
            daltx = 1'b1;
            dalbe = 1'b1;
            twtbt = req_write;
            tbs7  = is_io_page(req_addr);
            if (cnt == AHOLD_LAST)
               next_state = ST_DPREP;
         end
         ST_DPREP: begin
            tsync = 1'b1;
            if (req_write) begin
               tdal  = {6'b0, req_wdata};
               daltx = 1'b1;
               dalbe = 1'b1;
               dalst = (cnt == '0);
               twtbt = req_byte;
               if (cnt == DSKEW_LAST)
                  next_state = ST_XFER;
            end else begin
               next_state = ST_XFER;
            end
         end
         ST_XFER: begin
            // A reply arriving on the timeout cycle takes precedence over NXM.
            if (!rply_s && cnt == NXM_LIMIT) begin
               nxm_c      = 1'b1;
               next_state = ST_IDLE;
            end else begin
               tsync = 1'b1;
               tdout = req_write;
               tdin  = !req_write;
               if (req_write) begin
                  tdal  = {6'b0, req_wdata};
                  daltx = 1'b1;
                  dalbe = 1'b1;
                  twtbt = req_byte;
               end
               if (rply_s)
                  next_state = req_write ? ST_RELEASE : ST_DSETL;
            end
         end
         ST_DSETL: begin
            tsync = 1'b1;
            tdin  = 1'b1;
            if (cnt == SETTLE_LAST) begin
               sample_rdal = 1'b1;
               next_state  = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (rply_s && cnt == NXM_LIMIT) begin
               nxm_c      = 1'b1;
               next_state = ST_IDLE;
            end else begin
               tsync = 1'b1;
               // DATO data stays on the lines until the slave drops RRPLY.
               if (req_write) begin
                  tdal  = {6'b0, req_wdata};
                  daltx = 1'b1;
                  dalbe = 1'b1;
                  twtbt = req_byte;
               end
               if (!rply_s)
                  next_state = ST_FIN;
            end
         end
         ST_FIN: begin
            done_c     = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase

      // A cycle being aborted by BINIT never reports completion.
      if (bus.RINIT) begin
         done_c = 1'b0;
         nxm_c  = 1'b0;
      end
   end

   assign bus.busy  = (state != ST_IDLE);
   assign bus.done  = done_c;
   assign bus.nxm   = nxm_c;
   assign bus.rdata = rdata_q;
   assign bus.TDAL  = tdal;
   assign bus.TWTBT = twtbt;
   assign bus.TBS7  = tbs7;
   assign bus.TSYNC = tsync;
   assign bus.TDIN  = tdin;
   assign bus.TDOUT = tdout;
   assign bus.DALtx = daltx;
   assign bus.DALst = dalst;
   assign bus.DALbe = dalbe;

endmodule

// File: tb/tb_qbus_cycle_master.sv
// tb/tb_qbus_cycle_master.sv - scoreboard bench for qbus_cycle_master
module tb_qbus_cycle_master;

   logic clk20   = 1'b0;
   logic reset_L = 1'b0;
   always #25 clk20 = ~clk20;

   qbus_cycle_master_if bus();

   qbus_cycle_master dut (
      .clk20   (clk20),
      .reset_L (reset_L),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk20) cyc <= cyc + 1;

   typedef struct {
      bit          is_nxm;
      bit          chk_rdata;
      logic [15:0] rdata;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] outs_all();
      return {15'b0, bus.busy, bus.done, bus.nxm, bus.rdata, bus.TDAL, bus.TWTBT, bus.TBS7,
              bus.TSYNC, bus.TDIN, bus.TDOUT, bus.DALtx, bus.DALst, bus.DALbe};
   endfunction

   // Responder: mode 0 silent, 1 normal (RRPLY follows DIN/DOUT, released 3 cycles late),
   // 2 RRPLY asserts and sticks.
   int          resp_mode = 0;
   logic [15:0] resp_data = '0;
   initial begin
      int low_n = 0;
      bus.RRPLY = 1'b0;
      bus.RDAL  = '0;
      forever begin
         @(negedge clk20);
         bus.RDAL = resp_data;
         case (resp_mode)
            1: begin
               if (bus.TDIN || bus.TDOUT) begin
                  bus.RRPLY = 1'b1;
                  low_n = 0;
               end else if (bus.RRPLY) begin
                  low_n++;
                  if (low_n >= 3) bus.RRPLY = 1'b0;
               end
            end
            2: if (bus.TDIN || bus.TDOUT) bus.RRPLY = 1'b1;
            default: bus.RRPLY = 1'b0;
         endcase
      end
   end

   // Observation records, cleared per transaction.
   logic [21:0] rec_addr_tdal, rec_data_tdal;
   logic        rec_addr_wtbt, rec_addr_bs7, rec_data_wtbt;
   int          rec_dalbe_cyc, rec_sync_cyc, rec_dst_cyc, rec_dout_cyc, rec_din_cyc, rec_nxm_cyc;
   logic [4:0]  rec_nxm_bus;
   int          hold_n, hold_bad;
   logic [15:0] hold_exp = '0;

   task automatic clear_rec();
      rec_addr_tdal = '0; rec_data_tdal = '0;
      rec_addr_wtbt = 1'b0; rec_addr_bs7 = 1'b0; rec_data_wtbt = 1'b0;
      rec_dalbe_cyc = -1; rec_sync_cyc = -1; rec_dst_cyc = -1;
      rec_dout_cyc = -1; rec_din_cyc = -1; rec_nxm_cyc = -1;
      rec_nxm_bus = '1;
      hold_n = 0; hold_bad = 0;
   endtask

   // Monitor: scoreboard pops on done/nxm, records phase timing, checks invariants.
   initial begin
      logic prev_dalbe = 1'b0, prev_sync = 1'b0, prev_dout = 1'b0, prev_din = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk20);
         #1;
         if (bus.done || bus.nxm) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_completion: done=%0b nxm=%0b required none", bus.done, bus.nxm);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_done_nxm"}, {62'b0, bus.done, bus.nxm}, e.is_nxm ? 64'd1 : 64'd2);
               if (e.chk_rdata)
                  check({e.name, "_rdata"}, bus.rdata, e.rdata);
            end
         end
         check("inv_din_dout", bus.TDIN & bus.TDOUT, 0);
         check("inv_daltx_din", bus.DALtx & bus.TDIN, 0);
         if (!reset_L || !bus.busy) check("inv_sync_idle", bus.TSYNC, 0);

         if (bus.DALst && !bus.TSYNC) begin
            rec_addr_tdal = bus.TDAL; rec_addr_wtbt = bus.TWTBT; rec_addr_bs7 = bus.TBS7;
         end
         if (bus.DALst && bus.TSYNC) begin
            rec_dst_cyc = cyc; rec_data_wtbt = bus.TWTBT; rec_data_tdal = bus.TDAL;
         end
         if (bus.DALbe && !prev_dalbe && !bus.TSYNC) rec_dalbe_cyc = cyc;
         if (bus.TSYNC && !prev_sync) rec_sync_cyc = cyc;
         if (bus.TDOUT && !prev_dout) rec_dout_cyc = cyc;
         if (bus.TDIN && !prev_din) rec_din_cyc = cyc;
         if (bus.nxm) begin
            rec_nxm_cyc = cyc;
            rec_nxm_bus = {bus.TSYNC, bus.TDIN, bus.TDOUT, bus.DALbe, bus.DALtx};
         end
         if (bus.TSYNC && bus.RRPLY && !bus.TDOUT && bus.DALtx) begin
            hold_n++;
            if (bus.TDAL !== {6'b0, hold_exp}) hold_bad++;
         end
         prev_dalbe = bus.DALbe; prev_sync = bus.TSYNC;
         prev_dout = bus.TDOUT; prev_din = bus.TDIN;
      end
   end

   task automatic push_exp(input bit is_nxm, input bit chk, input logic [15:0] rd, input string name);
      exp_t e;
      e.is_nxm = is_nxm; e.chk_rdata = chk; e.rdata = rd; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic issue(input bit wr, input bit bt, input logic [21:0] a, input logic [15:0] wd);
      @(negedge clk20);
      bus.start = 1'b1; bus.write = wr; bus.byte_mode = bt; bus.addr = a; bus.wdata = wd;
      @(negedge clk20);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n = 0;
      while (bus.busy && n < max_cyc) begin
         @(negedge clk20);
         n++;
      end
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, max_cyc);
      end
      @(negedge clk20);
   endtask

   // Waits (bounded) for TDIN (sel=0) or RRPLY (sel=1), sampling just after the falling edge.
   task automatic wait_level(input string name, input bit sel, input int max_cyc);
      int n = 0;
      @(negedge clk20); #2;
      while (!(sel ? bus.RRPLY : bus.TDIN) && n < max_cyc) begin
         @(negedge clk20); #2;
         n++;
      end
      if (!(sel ? bus.RRPLY : bus.TDIN)) begin
         checks++;
         errors++;
         $display("FAIL %s_wait: level not seen in %0d cycles, required 1", name, max_cyc);
      end
   endtask

   initial begin
      bus.RINIT = 1'b0; bus.start = 1'b0; bus.write = 1'b0; bus.byte_mode = 1'b0;
      bus.addr = '0; bus.wdata = '0;
      clear_rec();
      repeat (3) @(negedge clk20);
      check("reset_outputs", outs_all(), 64'd0);
      reset_L = 1'b1;
      repeat (2) @(negedge clk20);

      // DATI from the I/O page.
      clear_rec();
      resp_mode = 1; resp_data = 16'o123456;
      push_exp(1'b0, 1'b1, 16'o123456, "dati");
      issue(1'b0, 1'b0, 22'o17777570, 16'h0);
      wait_idle("dati", 400);
      check("dati_addr_tdal", rec_addr_tdal, 22'o17777570);
      check("dati_addr_bs7", rec_addr_bs7, 1);
      check("dati_addr_wtbt", rec_addr_wtbt, 0);
      check("dati_sync_after_dalbe", rec_sync_cyc - rec_dalbe_cyc, 3);
      check("dati_rdata_kept", bus.rdata, 16'o123456);

      // DATO word.
      clear_rec();
      hold_exp = 16'o052525;
      push_exp(1'b0, 1'b0, 16'h0, "dato");
      issue(1'b1, 1'b0, 22'o1000, 16'o052525);
      wait_idle("dato", 400);
      check("dato_addr_wtbt", rec_addr_wtbt, 1);
      check("dato_addr_bs7", rec_addr_bs7, 0);
      check("dato_addr_tdal", rec_addr_tdal, 22'o1000);
      check("dato_data_tdal", rec_data_tdal, {6'b0, 16'o052525});
      check("dato_data_wtbt", rec_data_wtbt, 0);
      check("dato_dout_after_dalst", rec_dout_cyc - rec_dst_cyc, 2);
      check("dato_hold_seen", hold_n > 0, 1);
      check("dato_hold_data", hold_bad, 0);
      check("dato_rdata_unchanged", bus.rdata, 16'o123456);

      // DATOB.
      clear_rec();
      hold_exp = 16'o000252;
      push_exp(1'b0, 1'b0, 16'h0, "datob");
      issue(1'b1, 1'b1, 22'o1001, 16'o000252);
      wait_idle("datob", 400);
      check("datob_addr_wtbt", rec_addr_wtbt, 1);
      check("datob_data_wtbt", rec_data_wtbt, 1);
      check("datob_hold_data", hold_bad, 0);

      // DATI with no responder: NXM.
      clear_rec();
      resp_mode = 0;
      push_exp(1'b1, 1'b0, 16'h0, "nxm");
      issue(1'b0, 1'b0, 22'o2000, 16'h0);
      wait_idle("nxm", 400);
      check("nxm_after_din", rec_nxm_cyc - rec_din_cyc, 200);
      check("nxm_bus_negated", rec_nxm_bus, 0);
      check("nxm_rdata_unchanged", bus.rdata, 16'o123456);

      // RINIT while in XFER.
      clear_rec();
      issue(1'b0, 1'b0, 22'o3000, 16'h0);
      wait_level("rinit_xfer", 1'b0, 20);
      repeat (2) @(negedge clk20);
      bus.RINIT = 1'b1;
      @(negedge clk20);
      bus.RINIT = 1'b0;
      #1;
      check("rinit_xfer_outputs", outs_all(), 64'd0);
      repeat (10) @(negedge clk20);

      // RINIT while in DSETL.
      clear_rec();
      resp_mode = 1; resp_data = 16'o000007;
      issue(1'b0, 1'b0, 22'o4000, 16'h0);
      wait_level("rinit_dsetl", 1'b1, 40);
      repeat (3) @(negedge clk20);
      check("rinit_dsetl_din_before", bus.TDIN, 1);
      bus.RINIT = 1'b1;
      @(negedge clk20);
      bus.RINIT = 1'b0;
      #1;
      check("rinit_dsetl_outputs", outs_all(), 64'd0);
      repeat (10) @(negedge clk20);

      // RRPLY stuck in RELEASE plus a start while busy.
      clear_rec();
      resp_mode = 2;
      push_exp(1'b1, 1'b0, 16'h0, "stuck");
      issue(1'b1, 1'b0, 22'o1000, 16'o000001);
      repeat (5) @(negedge clk20);
      issue(1'b0, 1'b0, 22'o5000, 16'h0);
      wait_idle("stuck", 600);
      resp_mode = 0;
      repeat (20) @(negedge clk20);
      check("stuck_second_start_ignored", bus.busy, 0);
      check("stuck_bus_idle", bus.TSYNC, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
